// File: rtl/crop_pkg.sv
// Shared types and helpers for the crop/stride window extractor:
// width helpers, per-frame configuration legality check and FSM states.
package crop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DISCARD
  } state_t;

  // Bits needed to index 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return idx_width(n + 1);
  endfunction

  // 32-bit unsigned arithmetic leaves ample headroom over RW+SW+1 bits.
  function automatic logic cfg_legal(
    input logic [31:0] y1,
    input logic [31:0] x1,
    input logic [31:0] sy,
    input logic [31:0] sx,
    input logic [31:0] in_rows,
    input logic [31:0] in_cols,
    input logic [31:0] out_rows,
    input logic [31:0] out_cols,
    input logic [31:0] max_stride
  );
    logic ok;
    ok = (sy >= 32'd1) && (sy <= max_stride) &&
         (sx >= 32'd1) && (sx <= max_stride) &&
         (y1 + (out_rows - 32'd1) * sy <= in_rows - 32'd1) &&
         (x1 + (out_cols - 32'd1) * sx <= in_cols - 32'd1);
    return ok;
  endfunction

endpackage

// File: rtl/crop_stride_filter_if.sv
// Pixel stream in/out, frame markers and per-frame window configuration
// of the crop/stride filter, bundled with DUT-side and source-side views.
interface crop_stride_filter_if
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 9,
  parameter int IN_COLS         = 9,
  parameter int MAX_STRIDE      = 4
);
  localparam int DW = PIXEL_BIT_WIDTH * CHANNELS;
  localparam int RW = idx_width(IN_ROWS);
  localparam int CW = idx_width(IN_COLS);
  localparam int SW = idx_width(MAX_STRIDE + 1);

  logic [DW-1:0] pixel_in;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] pixel_out;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic [RW-1:0] cfg_y1;
  logic [CW-1:0] cfg_x1;
  logic [SW-1:0] cfg_stride_y;
  logic [SW-1:0] cfg_stride_x;
  logic          cfg_err;

  modport slave (
    input  pixel_in, in_valid, out_ready,
    input  cfg_y1, cfg_x1, cfg_stride_y, cfg_stride_x,
    output in_ready, pixel_out, out_valid, out_first, out_last, cfg_err
  );

  modport master (
    output pixel_in, in_valid, out_ready,
    output cfg_y1, cfg_x1, cfg_stride_y, cfg_stride_x,
    input  in_ready, pixel_out, out_valid, out_first, out_last, cfg_err
  );

endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer with a registered ready: ready never depends
// combinationally on the downstream ready, yet one beat per cycle sustains.
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_ready;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_next;

  assign w_push       = i_valid & r_ready;
  assign w_pop        = (r_count != 2'd0) & i_ready;
  assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the two entries are reset because they drive the output
      // directly and the output must read zero out of reset; larger
      // storage would normally be left unreset.
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_next;
      r_ready <= (w_count_next != 2'd2);
    end
  end

  assign o_ready = r_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/crop_stride_filter.sv
// Streaming region-of-interest extractor: keeps an OUT_ROWS x OUT_COLS
// window (with per-axis stride) from each raster frame, config latched per frame.
module crop_stride_filter
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 8,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 9,
  parameter int IN_COLS         = 9,
  parameter int OUT_ROWS        = 3,
  parameter int OUT_COLS        = 3,
  parameter int MAX_STRIDE      = 4
) (
  input logic                 clk,
  input logic                 reset,
  crop_stride_filter_if.slave bus
);

  localparam int DW  = PIXEL_BIT_WIDTH * CHANNELS;
  localparam int RW  = idx_width(IN_ROWS);
  localparam int CW  = idx_width(IN_COLS);
  localparam int SW  = idx_width(MAX_STRIDE + 1);
  localparam int RCW = cnt_width(OUT_ROWS);
  localparam int CCW = cnt_width(OUT_COLS);

  localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);

  state_t r_state, w_state_next;

  logic [RW-1:0]  r_row;
  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_y1;
  logic [CW-1:0]  r_x1;
  logic [SW-1:0]  r_sy;
  logic [SW-1:0]  r_sx;
  logic [SW-1:0]  r_row_phase;
  logic [SW-1:0]  r_col_phase;
  logic [RCW-1:0] r_row_cnt;
  logic [CCW-1:0] r_col_cnt;
  logic           r_cfg_err;

  logic          w_buf_ready;
  logic          w_beat;
  logic          w_frame_start;
  logic          w_col_wrap;
  logic          w_frame_end;
  logic          w_cfg_ok;
  logic          w_legal;
  logic [RW-1:0] w_y1;
  logic [CW-1:0] w_x1;
  logic [SW-1:0] w_sy;
  logic [SW-1:0] w_sx;
  logic          w_row_hit;
  logic          w_col_hit;
  logic          w_keep;
  logic          w_first;
  logic          w_last;
  logic [DW+1:0] w_buf_out;

  assign bus.in_ready  = w_buf_ready & ~reset;
  assign w_beat        = bus.in_valid & bus.in_ready;
  assign w_frame_start = w_beat && (r_row == '0) && (r_col == '0);
  assign w_col_wrap    = (r_col == COL_LAST);
  assign w_frame_end   = w_col_wrap && (r_row == ROW_LAST);

  assign w_cfg_ok = cfg_legal(32'(bus.cfg_y1), 32'(bus.cfg_x1),
                              32'(bus.cfg_stride_y), 32'(bus.cfg_stride_x),
                              32'(IN_ROWS), 32'(IN_COLS),
                              32'(OUT_ROWS), 32'(OUT_COLS), 32'(MAX_STRIDE));

  // The (0,0) beat is decided with the live config that is latched on that same edge.
  assign w_y1    = w_frame_start ? bus.cfg_y1       : r_y1;
  assign w_x1    = w_frame_start ? bus.cfg_x1       : r_x1;
  assign w_sy    = w_frame_start ? bus.cfg_stride_y : r_sy;
  assign w_sx    = w_frame_start ? bus.cfg_stride_x : r_sx;
  assign w_legal = w_frame_start ? w_cfg_ok : (r_state == ST_ACTIVE);

  assign w_row_hit = (r_row >= w_y1) && (r_row_phase == '0) && (r_row_cnt < RCW'(OUT_ROWS));
  assign w_col_hit = (r_col >= w_x1) && (r_col_phase == '0) && (r_col_cnt < CCW'(OUT_COLS));
  assign w_keep    = w_beat & w_legal & w_row_hit & w_col_hit;
  assign w_first   = (r_row_cnt == '0) && (r_col_cnt == '0);
  assign w_last    = (r_row_cnt == RCW'(OUT_ROWS - 1)) && (r_col_cnt == CCW'(OUT_COLS - 1));

  // NOTE: next-state defaults to the current state first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    if (w_beat) begin
      if (w_frame_end) begin
        w_state_next = ST_IDLE;
      end else if (w_frame_start) begin
        w_state_next = w_cfg_ok ? ST_ACTIVE : ST_DISCARD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cfg_err <= 1'b0;
      r_y1      <= '0;
      r_x1      <= '0;
      r_sy      <= '0;
      r_sx      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cfg_err <= w_frame_start & ~w_cfg_ok;
      if (w_frame_start) begin
        r_y1 <= bus.cfg_y1;
        r_x1 <= bus.cfg_x1;
        r_sy <= bus.cfg_stride_y;
        r_sx <= bus.cfg_stride_x;
      end
    end
  end

  // Raster position plus stride phase trackers; phases reload on a hit and
  // count down otherwise, which replaces any modulo arithmetic.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_row_phase <= '0;
      r_col_phase <= '0;
      r_row_cnt   <= '0;
      r_col_cnt   <= '0;
    end else if (w_beat) begin
      if (w_col_wrap) begin
        r_col       <= '0;
        r_row       <= w_frame_end ? '0 : r_row + 1'b1;
        r_col_phase <= '0;
        r_col_cnt   <= '0;
      end else begin
        r_col <= r_col + 1'b1;
        if (r_col >= w_x1) begin
          if (w_col_hit) begin
            r_col_phase <= w_sx - 1'b1;
            r_col_cnt   <= r_col_cnt + 1'b1;
          end else if (r_col_phase != '0) begin
            r_col_phase <= r_col_phase - 1'b1;
          end
        end
      end

      if (w_frame_end) begin
        r_row_phase <= '0;
        r_row_cnt   <= '0;
      end else if (w_col_wrap && (r_row >= w_y1)) begin
        if (w_row_hit) begin
          r_row_phase <= w_sy - 1'b1;
          r_row_cnt   <= r_row_cnt + 1'b1;
        end else if (r_row_phase != '0) begin
          r_row_phase <= r_row_phase - 1'b1;
        end
      end
    end
  end

  stream_skid_buffer #(
    .WIDTH (DW + 2)
  ) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .i_data  ({w_first, w_last, bus.pixel_in}),
    .i_valid (w_keep),
    .o_ready (w_buf_ready),
    .o_data  (w_buf_out),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready)
  );

  assign bus.out_first = w_buf_out[DW+1];
  assign bus.out_last  = w_buf_out[DW];
  assign bus.pixel_out = w_buf_out[DW-1:0];
  assign bus.cfg_err   = r_cfg_err;

endmodule
